// File: rtl/window_set_buffer.sv
// window_set_buffer
// Circular store of data sets. A write deposits 0..IN_NUM_OF_SET sets at once,
// and the WINDOW oldest sets are presented on dout. Each accepted handshake
// retires STRIDE sets.
// Optional feature macro: WINDOW_SET_BUFFER_OVERFLOW_EN.
//   Defined:   overflow is a sticky flag for dropped non-empty writes.
//   Undefined: overflow is tied low.
module window_set_buffer #(
    parameter int DATA_WIDTH    = 32,
    parameter int DATA_OF_SET   = 128,
    parameter int IN_NUM_OF_SET = 16,
    parameter int BUFFER_SIZE   = 32,
    parameter int WINDOW        = 3,
    parameter int STRIDE        = 1
) (
    input  logic                                                    clk,
    input  logic                                                    rst,
    input  logic                                                    flush,
    input  logic                                                    wen,
    input  logic [$clog2(IN_NUM_OF_SET+1)-1:0]                      din_count,
    input  logic [IN_NUM_OF_SET-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0] din,
    output logic                                                    full_flag,
    output logic [WINDOW-1:0][DATA_OF_SET-1:0][DATA_WIDTH-1:0]      dout,
    output logic                                                    dout_valid,
    input  logic                                                    dout_ready,
    output logic [$clog2(BUFFER_SIZE+1)-1:0]                        level,
    output logic                                                    overflow
);
    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int LVL_W = $clog2(BUFFER_SIZE+1);
    localparam int CNT_W = $clog2(IN_NUM_OF_SET+1);

    // Full when the free space cannot take a maximum-size write.
    localparam logic [LVL_W-1:0] FULL_THRESH = LVL_W'(BUFFER_SIZE - IN_NUM_OF_SET);
    localparam logic [LVL_W-1:0] WINDOW_L    = LVL_W'(WINDOW);
    localparam logic [LVL_W-1:0] STRIDE_L    = LVL_W'(STRIDE);
    localparam logic [CNT_W-1:0] MAX_CNT     = CNT_W'(IN_NUM_OF_SET);

    typedef logic [DATA_OF_SET-1:0][DATA_WIDTH-1:0] set_t;

    set_t             mem_r [BUFFER_SIZE];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic             full_r;
    logic             valid_r;

    logic [CNT_W-1:0] wr_cnt_s;
    logic             wr_en_s;
    logic             pop_s;
    logic [LVL_W-1:0] level_next_s;

    // Saturate the write count, qualify write/pop, and derive the next fill level
    always_comb begin
        wr_cnt_s     = din_count;
        wr_en_s      = 1'b0;
        pop_s        = 1'b0;
        level_next_s = level_r;
        if (din_count > MAX_CNT) begin
            wr_cnt_s = MAX_CNT;
        end else begin
            wr_cnt_s = din_count;
        end
        // Space is judged on the registered level only; a same-cycle pop frees nothing.
        wr_en_s = wen && !full_r && !flush;
        pop_s   = valid_r && dout_ready && !flush;
        if (flush) begin
            level_next_s = {LVL_W{1'b0}};
        end else begin
            level_next_s = level_r
                         + (wr_en_s ? LVL_W'(wr_cnt_s) : {LVL_W{1'b0}})
                         - (pop_s   ? STRIDE_L         : {LVL_W{1'b0}});
        end
    end

    // Pointers, fill level and the status flags registered from the next level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            full_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            level_r  <= {LVL_W{1'b0}};
            full_r   <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(wr_cnt_s);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(STRIDE);
            end
            level_r <= level_next_s;
            full_r  <= (level_next_s > FULL_THRESH);
            valid_r <= (level_next_s >= WINDOW_L);
        end
    end

    // Set storage (never reset): only the sets covered by an accepted write change
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < IN_NUM_OF_SET; i++) begin
                if (CNT_W'(i) < wr_cnt_s) begin
                    mem_r[wr_ptr_r + PTR_W'(i)] <= din[i];
                end
            end
        end
    end

    // Window: WINDOW consecutive sets from the read pointer, wrapping the store
    always_comb begin
        for (int k = 0; k < WINDOW; k++) begin
            dout[k] = mem_r[rd_ptr_r + PTR_W'(k)];
        end
    end

`ifdef WINDOW_SET_BUFFER_OVERFLOW_EN
    logic overflow_r;

    // Sticky record of a non-empty write that was dropped because the store was full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (flush) begin
            overflow_r <= 1'b0;
        end else if (wen && full_r && (din_count != {CNT_W{1'b0}})) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign overflow = overflow_r;
`else
    assign overflow = 1'b0;
`endif

    assign full_flag  = full_r;
    assign dout_valid = valid_r;
    assign level      = level_r;

endmodule

// File: tb/tb_window_set_buffer.sv
// Testbench for window_set_buffer: two instances (STRIDE=1 with full-size sets,
// STRIDE=2 with small sets) checked against queue-based reference models.
module tb_window_set_buffer;
    localparam int DW_A = 32;
    localparam int DS_A = 128;
    localparam int DW_B = 8;
    localparam int DS_B = 4;
    localparam int IN_N = 16;
    localparam int BUF  = 32;
    localparam int WIN  = 3;

`ifdef WINDOW_SET_BUFFER_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef logic [DS_A-1:0][DW_A-1:0] set_a_t;
    typedef logic [DS_B-1:0][DW_B-1:0] set_b_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic                                  flush_a = 1'b0, wen_a = 1'b0, ready_a = 1'b0;
    logic [4:0]                            cnt_a = 5'd0;
    logic [IN_N-1:0][DS_A-1:0][DW_A-1:0]   din_a;
    logic                                  full_a, valid_a, ovf_a;
    logic [5:0]                            level_a;
    logic [WIN-1:0][DS_A-1:0][DW_A-1:0]    dout_a;

    logic                                  flush_b = 1'b0, wen_b = 1'b0, ready_b = 1'b0;
    logic [4:0]                            cnt_b = 5'd0;
    logic [IN_N-1:0][DS_B-1:0][DW_B-1:0]   din_b;
    logic                                  full_b, valid_b, ovf_b;
    logic [5:0]                            level_b;
    logic [WIN-1:0][DS_B-1:0][DW_B-1:0]    dout_b;

    set_a_t qa[$];
    set_b_t qb[$];
    bit     movf_a = 1'b0;
    bit     movf_b = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    window_set_buffer #(
        .DATA_WIDTH(DW_A), .DATA_OF_SET(DS_A), .IN_NUM_OF_SET(IN_N),
        .BUFFER_SIZE(BUF), .WINDOW(WIN), .STRIDE(1)
    ) dut_a (
        .clk(clk), .rst(rst), .flush(flush_a), .wen(wen_a), .din_count(cnt_a),
        .din(din_a), .full_flag(full_a), .dout(dout_a), .dout_valid(valid_a),
        .dout_ready(ready_a), .level(level_a), .overflow(ovf_a)
    );

    window_set_buffer #(
        .DATA_WIDTH(DW_B), .DATA_OF_SET(DS_B), .IN_NUM_OF_SET(IN_N),
        .BUFFER_SIZE(BUF), .WINDOW(WIN), .STRIDE(2)
    ) dut_b (
        .clk(clk), .rst(rst), .flush(flush_b), .wen(wen_b), .din_count(cnt_b),
        .din(din_b), .full_flag(full_b), .dout(dout_b), .dout_valid(valid_b),
        .dout_ready(ready_b), .level(level_b), .overflow(ovf_b)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: apply the pre-edge inputs to the queues of held sets.
    task automatic model_update();
        int n;
        bit full;
        bit valid;
        if (rst) begin
            qa.delete(); qb.delete();
            movf_a = 1'b0; movf_b = 1'b0;
            return;
        end
        n     = (cnt_a > 5'd16) ? IN_N : int'(cnt_a);
        full  = (BUF - qa.size()) < IN_N;
        valid = qa.size() >= WIN;
        if (flush_a) begin
            qa.delete(); movf_a = 1'b0;
        end else begin
            if (valid && ready_a) void'(qa.pop_front());
            if (wen_a && full) begin
                if (cnt_a != 5'd0) movf_a = OVF_EN;
            end else if (wen_a) begin
                for (int i = 0; i < n; i++) qa.push_back(din_a[i]);
            end
        end
        n     = (cnt_b > 5'd16) ? IN_N : int'(cnt_b);
        full  = (BUF - qb.size()) < IN_N;
        valid = qb.size() >= WIN;
        if (flush_b) begin
            qb.delete(); movf_b = 1'b0;
        end else begin
            if (valid && ready_b) repeat (2) void'(qb.pop_front());
            if (wen_b && full) begin
                if (cnt_b != 5'd0) movf_b = OVF_EN;
            end else if (wen_b) begin
                for (int i = 0; i < n; i++) qb.push_back(din_b[i]);
            end
        end
    endtask

    task automatic check_all();
        int w;
        check_val("level_a", 64'(level_a), 64'(qa.size()));
        check_val("valid_a", 64'(valid_a), 64'(qa.size() >= WIN));
        check_val("full_a",  64'(full_a),  64'((BUF - qa.size()) < IN_N));
        check_val("ovf_a",   64'(ovf_a),   64'(movf_a));
        check_val("level_b", 64'(level_b), 64'(qb.size()));
        check_val("valid_b", 64'(valid_b), 64'(qb.size() >= WIN));
        check_val("full_b",  64'(full_b),  64'((BUF - qb.size()) < IN_N));
        check_val("ovf_b",   64'(ovf_b),   64'(movf_b));
        if (qa.size() >= WIN) begin
            for (int k = 0; k < WIN; k++) begin
                w = -1;
                for (int j = 0; j < DS_A; j++)
                    if (w < 0 && dout_a[k][j] !== qa[k][j]) w = j;
                if (w < 0) w = 0;
                check_val($sformatf("dout_a[%0d][%0d]", k, w), 64'(dout_a[k][w]), 64'(qa[k][w]));
            end
        end
        if (qb.size() >= WIN) begin
            for (int k = 0; k < WIN; k++)
                check_val($sformatf("dout_b[%0d]", k), 64'(dout_b[k]), 64'(qb[k]));
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic fill_a_const(input int base);
        for (int i = 0; i < IN_N; i++)
            for (int j = 0; j < DS_A; j++) din_a[i][j] = 32'(base + i);
    endtask

    task automatic fill_a_rand();
        for (int i = 0; i < IN_N; i++)
            for (int j = 0; j < DS_A; j++) din_a[i][j] = $urandom;
    endtask

    task automatic fill_b_rand();
        for (int i = 0; i < IN_N; i++)
            for (int j = 0; j < DS_B; j++) din_b[i][j] = 8'($urandom);
    endtask

    initial begin
        fill_a_rand();
        fill_b_rand();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Fill a with sets whose words equal k+1; b gets three random sets.
        fill_a_const(1); wen_a = 1'b1; cnt_a = 5'd16;
        fill_b_rand();   wen_b = 1'b1; cnt_b = 5'd3;
        tick();
        // Second full write on a; on b, write 5 while popping 2.
        fill_a_const(17);
        fill_b_rand(); cnt_b = 5'd5; ready_b = 1'b1;
        tick();
        wen_b = 1'b0; ready_b = 1'b0;
        // Write into a full store is dropped.
        fill_a_rand(); cnt_a = 5'd16;
        tick();
        // Drain 30 sets one per cycle.
        wen_a = 1'b0; ready_a = 1'b1;
        repeat (30) tick();
        // Bring a to 3 sets (window wraps the store end), then write 5 while popping.
        ready_a = 1'b0; wen_a = 1'b1; cnt_a = 5'd1; fill_a_rand();
        tick();
        cnt_a = 5'd5; ready_a = 1'b1; fill_a_rand();
        tick();
        // Flush beats a simultaneous write and pop.
        flush_a = 1'b1; cnt_a = 5'd4; ready_a = 1'b1;
        flush_b = 1'b1; wen_b = 1'b1; cnt_b = 5'd4; ready_b = 1'b1;
        tick();
        flush_a = 1'b0; flush_b = 1'b0;

        // Randomized traffic: light writes first, heavy writes later.
        for (int c = 0; c < 400; c++) begin
            int wp;
            wp = (c < 200) ? 2 : 6;
            wen_a   = ($urandom_range(0, 9) < wp);
            cnt_a   = 5'($urandom_range(0, 20));
            ready_a = ($urandom_range(0, 9) < 6);
            flush_a = ($urandom_range(0, 39) == 0);
            if (wen_a) fill_a_rand();
            wen_b   = ($urandom_range(0, 9) < wp);
            cnt_b   = 5'($urandom_range(0, 20));
            ready_b = ($urandom_range(0, 9) < 5);
            flush_b = ($urandom_range(0, 39) == 0);
            if (wen_b) fill_b_rand();
            tick();
        end

        // Make both non-empty, then assert reset between clock edges.
        flush_a = 1'b0; flush_b = 1'b0; ready_a = 1'b0; ready_b = 1'b0;
        wen_a = 1'b1; cnt_a = 5'd8; fill_a_rand();
        wen_b = 1'b1; cnt_b = 5'd8; fill_b_rand();
        tick();
        wen_a = 1'b0; wen_b = 1'b0;
        #2 rst = 1'b1;
        #1;
        qa.delete(); qb.delete(); movf_a = 1'b0; movf_b = 1'b0;
        check_all();
        tick();
        rst = 1'b0;
        wen_a = 1'b1; cnt_a = 5'd4; fill_a_rand();
        wen_b = 1'b1; cnt_b = 5'd4; fill_b_rand();
        tick();
        wen_a = 1'b0; wen_b = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
